// File: rtl/conv_acc_pkg.sv
// Shared types and helpers for the convolution window accumulator.
// Saturating output mode is selected by the CONV_ACC_SATURATE_EN macro.
package conv_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int acc_width(input int in_w, input int lanes, input int win);
    return in_w + $clog2(lanes * win);
  endfunction

  function automatic int beat_width(input int win);
    return (win > 1) ? $clog2(win) : 1;
  endfunction

  // Clamp a sign-extended value into the signed range of an out_w-bit field.
  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] value,
                                                    input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/conv_window_accumulator_lane_adder_tree.sv
// Combinational sign-extending sum of LANES packed signed lanes.
module lane_adder_tree
  import conv_acc_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int LANES    = 3,
  localparam int SUM_WIDTH = IN_WIDTH + $clog2(LANES)
) (
  input  logic [LANES*IN_WIDTH-1:0]  in_data,
  output logic signed [SUM_WIDTH-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum = sum + SUM_WIDTH'(signed'(in_data[i*IN_WIDTH +: IN_WIDTH]));
    end
  end

endmodule

// File: rtl/conv_window_accumulator.sv
// Registered windowed accumulator: sums LANES products per beat over WIN_LEN beats.
// Define CONV_ACC_SATURATE_EN for clamping output resize and the out_sat flag.
module conv_window_accumulator
  import conv_acc_pkg::*;
#(
  parameter int IN_WIDTH  = 14,
  parameter int LANES     = 3,
  parameter int WIN_LEN   = 3,
  parameter int OUT_WIDTH = 18,
  localparam int BEAT_W   = beat_width(WIN_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*IN_WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic signed [OUT_WIDTH-1:0] out_sum,
  output logic                        out_valid,
  input  logic                        out_ready,
`ifdef CONV_ACC_SATURATE_EN
  output logic                        out_sat,
`endif
  output logic [BEAT_W-1:0]           beat_idx
);

  localparam int ACC_WIDTH = acc_width(IN_WIDTH, LANES, WIN_LEN);
  localparam int SUM_WIDTH = IN_WIDTH + $clog2(LANES);

  state_t                        state;
  logic signed [SUM_WIDTH-1:0]   lane_sum;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [OUT_WIDTH-1:0]   resized;
  logic                          accept;
  logic                          last_beat;
  logic                          window_done;

  lane_adder_tree #(
    .IN_WIDTH(IN_WIDTH),
    .LANES   (LANES)
  ) u_lanes (
    .in_data(in_data),
    .sum    (lane_sum)
  );

  // HOLD is purely the stalled-output condition, so it is derived rather than stored.
  always_comb begin
    state       = (out_valid && !out_ready) ? HOLD : ACCUM;
    in_ready    = (state == ACCUM);
    accept      = in_valid && in_ready;
    last_beat   = (beat_idx == BEAT_W'(WIN_LEN - 1));
    window_done = accept && last_beat && !flush;
    acc_next    = acc + ACC_WIDTH'(lane_sum);
  end

`ifdef CONV_ACC_SATURATE_EN
  logic signed [63:0] wide_sum;
  logic signed [63:0] clamped;
  logic               sat_hit;

  always_comb begin
    wide_sum = 64'(acc_next);
    clamped  = sat_resize(wide_sum, OUT_WIDTH);
    sat_hit  = (clamped != wide_sum);
    resized  = OUT_WIDTH'(clamped);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sat <= 1'b0;
    end else if (window_done) begin
      out_sat <= sat_hit;
    end
  end
`else
  always_comb begin
    resized = OUT_WIDTH'(acc_next);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      beat_idx <= '0;
    end else if (flush) begin
      acc      <= '0;
      beat_idx <= '0;
    end else if (accept) begin
      if (last_beat) begin
        acc      <= '0;
        beat_idx <= '0;
      end else begin
        acc      <= acc_next;
        beat_idx <= beat_idx + BEAT_W'(1);
      end
    end
  end

  // A final beat may reload the output in the same cycle the old value drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (window_done) begin
      out_sum   <= resized;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/conv_window_accumulator.md
Name: conv_window_accumulator

Overview:
- Registered, parametrised accumulator for the convolution datapath; the successor to the combinational single-input adder.
- Each accepted beat carries LANES signed products, which are summed and added to a running total.
- After WIN_LEN beats (one kernel window, e.g. 3 rows x 3 lanes = 3x3 kernel) it emits one signed window sum with valid/ready handshake, then restarts.
- Sits between the multiplier array and the pixel output/normalisation stage.

Parameters:
- IN_WIDTH, 14, width of each signed product lane.
- LANES, 3, number of products presented per beat (>=1).
- WIN_LEN, 3, beats per window (>=1).
- OUT_WIDTH, 18, width of out_sum. Full-precision width is ACC_WIDTH = IN_WIDTH + clog2(LANES*WIN_LEN) = 18 at defaults. OUT_WIDTH must be <= ACC_WIDTH.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_data, input, LANES*IN_WIDTH, packed signed lanes; lane i at bits [i*IN_WIDTH +: IN_WIDTH].
- in_valid, input, 1, beat present.
- in_ready, output, 1, block can accept a beat.
- flush, input, 1, synchronous discard of the partial window.
- out_sum, output, OUT_WIDTH, signed window sum.
- out_valid, output, 1, out_sum holds a completed window.
- out_ready, input, 1, downstream accepts out_sum.
- beat_idx, output, clog2(WIN_LEN) (min 1), index of the next beat expected in the window.

Behaviour:
- Reset (asynchronous, rst=1): acc=0, beat_idx=0, out_sum=0, out_valid=0, state=ACCUM. in_ready is 1 as soon as rst deasserts.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The output register drains and the final beat of the next window may load it in the same cycle; no bubble.
- Lane sum: combinational sign-extended sum of LANES inputs, width IN_WIDTH + clog2(LANES). The accumulator is ACC_WIDTH wide and never overflows internally.
- State ACCUM, non-final beat accepted (beat_idx < WIN_LEN-1): acc <= acc + lane_sum; beat_idx++.
- State ACCUM, final beat accepted (beat_idx == WIN_LEN-1):
  - out_sum <= resize(acc + lane_sum); out_valid <= 1.
  - acc <= 0; beat_idx <= 0; the window is complete.
- Latency: out_valid rises the cycle after the final beat is accepted.
- WIN_LEN=1 special case: every accepted beat is a final beat, giving throughput of one window per cycle.
- Output hold: out_valid && !out_ready keeps out_sum and out_valid stable, with in_ready=0 (state HOLD). Any beat presented is not accepted.
- Output drain: out_valid && out_ready with no final beat accepted gives out_valid <= 0.
- Simultaneous drain and final beat: out_valid stays 1 and out_sum is reloaded with the new window.
- flush:
  - flush=1 clears acc and beat_idx next cycle; a beat presented in the same cycle is dropped (in_ready is still reported, the beat is consumed and discarded).
  - flush does not affect out_sum/out_valid (a completed window is never lost).
- Reset mid-window: the partial sum is lost; no output is produced for it.
- resize (default): two's-complement truncation to OUT_WIDTH low bits (wrap).

Optional Feature:
- Macro: CONV_ACC_SATURATE_EN.
- Defined: resize clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The extra output port out_sat (1 bit, registered with out_sum, reset 0) is 1 when clamping occurred.
- Undefined: wrap truncation; out_sat port absent.
- With OUT_WIDTH == ACC_WIDTH both modes are identical and out_sat is always 0.

Decomposition:
- Package conv_acc_pkg:
  - state enum {ACCUM, HOLD};
  - function acc_width(in_w, lanes, win) returning in_w + clog2(lanes*win);
  - saturate function sat_resize(value, out_w).
- Sub-module lane_adder_tree: parametrised by IN_WIDTH and LANES; a purely combinational sign-extending sum of packed lanes. Instantiated once.

Test Plan:
1. Defaults, reset, then 3 beats {5,3,-2}, {7,0,0}, {1,1,1}, out_ready=1 -> out_valid one cycle after beat 3, out_sum=16. beat_idx sequence 0,1,2,0.
2. Back-to-back windows with out_ready=1, in_valid held 6 cycles, each beat {1,1,1} -> out_sum=9 twice, in_ready never low, no bubble.
3. Backpressure: window completes with out_ready=0 for 4 cycles -> out_sum and out_valid stable, in_ready=0, extra beats not consumed. out_ready=1 -> drain, and the next window's sum is correct.
4. flush after beat 1 ({100,0,0}), then full window {1,0,0}x3 -> out_sum=3. Also rst=1 mid-window (asynchronous, between edges) -> out_valid=0 immediately, and the next window sum excludes old data.
5. Extremes: all lanes -8192 for 3 beats -> out_sum = -73728 (ACC_WIDTH=18 fits). With OUT_WIDTH=16:
   - wrap build -> out_sum = -73728 mod 2^16 as signed = -8192;
   - CONV_ACC_SATURATE_EN build -> out_sum = -32768, out_sat=1.
6. WIN_LEN=1, LANES=1: stream 5,3,-2 with out_ready=1 -> out_sum 5,3,-2 on consecutive cycles, each one cycle after its input.
